audio_period_sched: RTL and testbench

AUDIO_PERIOD_SCHED -- requirements
Module: audio_period_sched

---
 rtl/audio_pkg.sv | 20 ++
 rtl/syncro_2.sv | 25 ++
 rtl/audio_period_sched.sv | 175 +++++++++++++++++
 tb/tb_audio_period_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio period scheduler.
//   sched_state_e : host-mode scheduler FSM states
//   ADDR_*        : CPU register addresses
package audio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitDone,
        StPush,
        StDone
    } sched_state_e;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_START  = 3'd3;
    localparam logic [2:0] ADDR_OVR    = 3'd4;

endpackage

// File: rtl/syncro_2.sv
// syncro_2: two-flop synchronizer for a single asynchronous bit.
//   clk   in  1  destination clock
//   rst_n in  1  async active-low reset, both flops clear to 0
//   d     in  1  asynchronous input
//   q     out 1  synchronized output
module syncro_2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/audio_period_sched.sv
// audio_period_sched: schedules synth sample generation for one audio period.
// Host mode (PERIOD != 0): a START write runs PERIOD trig/push rounds, then raises irq_pend.
// I2S mode (PERIOD == 0): each synchronized lrck rising edge emits trig, each voice_done
// emits a fifo_wr on the next cycle.
// Optional feature: define AUDIO_SCHED_OVR_CNT_EN for a 16-bit saturating counter of START
// writes that arrive while busy (address 4, cleared by any write to address 4).
// Ports:
//   clk, reset_reg_N              clock, async active-low reset
//   address, write, read, datain  CPU register port
//   dataout                       registered read data
//   lrck                          async I2S word clock
//   voice_done                    sample-pair-ready pulse from the synth
//   fifo_level                    current FIFO occupancy
//   trig, fifo_wr, irq            start pulse, FIFO push strobe, interrupt
//   i2s_enable                    high when PERIOD == 0
module audio_period_sched
    import audio_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH    = 6,
    parameter int unsigned AUD_BIT_DEPTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_reg_N,
    input  logic [2:0]            address,
    input  logic                  write,
    input  logic                  read,
    input  logic [31:0]           datain,
    output logic [31:0]           dataout,
    input  logic                  lrck,
    input  logic                  voice_done,
    input  logic [FIFO_WIDTH:0]   fifo_level,
    output logic                  trig,
    output logic                  fifo_wr,
    output logic                  irq,
    output logic                  i2s_enable
);

    localparam int unsigned CW = FIFO_WIDTH + 1;
    localparam logic [CW-1:0] FIFO_DEPTH = CW'(1) << FIFO_WIDTH;

    if (AUD_BIT_DEPTH > 32) begin : g_depth_check
        $error("AUD_BIT_DEPTH must not exceed 32");
    end

    sched_state_e  state_q, state_d;
    logic          run_q, irq_en_q, irq_pend_q;
    logic [CW-1:0] period_q, count_q, count_d, count_inc;
    logic          lrck_sync, lrck_prev, lrck_rise;
    logic          run_next, start_wr, busy, push, irq_set;
    logic [31:0]   rdata;
    logic          unused_datain;

    assign unused_datain = ^datain[31:CW];

    syncro_2 u_lrck_sync (
        .clk   (clk),
        .rst_n (reset_reg_N),
        .d     (lrck),
        .q     (lrck_sync)
    );

    assign lrck_rise  = lrck_sync & ~lrck_prev;
    assign i2s_enable = (period_q == '0);
    assign busy       = (state_q != StIdle);
    assign start_wr   = write && (address == ADDR_START);
    // Clearing run takes effect on the cycle after the CTRL write, not one later.
    assign run_next   = (write && (address == ADDR_CTRL)) ? datain[0] : run_q;
    assign count_inc  = count_q + CW'(1);
    assign irq        = irq_pend_q & irq_en_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        push    = 1'b0;
        irq_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_wr && run_q && (period_q != '0)) begin
                    state_d = StTrig;
                    count_d = '0;
                end
            end
            StTrig:     state_d = StWaitDone;
            StWaitDone: if (voice_done) state_d = StPush;
            StPush: begin
                if (fifo_level < FIFO_DEPTH) begin
                    push    = 1'b1;
                    count_d = count_inc;
                    state_d = (count_inc == period_q) ? StDone : StTrig;
                end
            end
            StDone: begin
                irq_set = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort: drop to IDLE, discard progress, leave irq_pend alone.
        if (!run_next && busy) begin
            state_d = StIdle;
            count_d = '0;
            push    = 1'b0;
            irq_set = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (address)
            ADDR_CTRL:   rdata[1:0] = {irq_en_q, run_q};
            ADDR_PERIOD: rdata[CW-1:0] = period_q;
            ADDR_STATUS: begin
                rdata[0]            = busy;
                rdata[1]            = irq_pend_q;
                rdata[16+CW-1:16]   = count_q;
            end
`ifdef AUDIO_SCHED_OVR_CNT_EN
            ADDR_OVR:    rdata[15:0] = ovr_q;
`endif
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q    <= StIdle;
            run_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= '0;
            count_q    <= '0;
            irq_pend_q <= 1'b0;
            lrck_prev  <= 1'b0;
            trig       <= 1'b0;
            fifo_wr    <= 1'b0;
            dataout    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lrck_prev <= lrck_sync;
            // trig/fifo_wr are registered: both strobes follow their cause by one cycle.
            trig      <= (state_d == StTrig) | (i2s_enable & run_q & lrck_rise);
            fifo_wr   <= push | (i2s_enable & run_q & voice_done);
            if (write && (address == ADDR_CTRL)) begin
                run_q    <= datain[0];
                irq_en_q <= datain[1];
            end
            if (write && (address == ADDR_PERIOD) && !busy) begin
                period_q <= datain[CW-1:0];
            end
            if (irq_set) begin
                irq_pend_q <= 1'b1;
            end else if (write && (address == ADDR_STATUS) && datain[1]) begin
                irq_pend_q <= 1'b0;
            end
            if (read) begin
                dataout <= rdata;
            end
        end
    end

`ifdef AUDIO_SCHED_OVR_CNT_EN
    logic [15:0] ovr_q;

    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            ovr_q <= '0;
        end else if (write && (address == ADDR_OVR)) begin
            ovr_q <= '0;
        end else if (start_wr && busy && (ovr_q != 16'hFFFF)) begin
            ovr_q <= ovr_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_period_sched.sv
// tb_audio_period_sched: directed, table-driven bench for audio_period_sched.
module tb_audio_period_sched;

    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          reset_reg_N = 1'b0;
    logic [2:0]    address = '0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [31:0]   datain = '0;
    logic [31:0]   dataout;
    logic          lrck = 1'b0;
    logic          voice_done = 1'b0;
    logic [FW:0]   fifo_level = '0;
    logic          trig, fifo_wr, irq, i2s_enable;

    int n_checks = 0;
    int n_errors = 0;
    int trig_total = 0;
    int wr_total = 0;

    audio_period_sched #(.FIFO_WIDTH(FW), .AUD_BIT_DEPTH(24)) dut (
        .clk         (clk),
        .reset_reg_N (reset_reg_N),
        .address     (address),
        .write       (write),
        .read        (read),
        .datain      (datain),
        .dataout     (dataout),
        .lrck        (lrck),
        .voice_done  (voice_done),
        .fifo_level  (fifo_level),
        .trig        (trig),
        .fifo_wr     (fifo_wr),
        .irq         (irq),
        .i2s_enable  (i2s_enable)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (trig)    trig_total++;
        if (fifo_wr) wr_total++;
    end

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        exp_i2s;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        datain  = d;
        write   = 1'b1;
        @(negedge clk);
        write   = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = dataout;
    endtask

    // Returns at the negedge where trig is seen; a timeout counts as a failure.
    task automatic wait_trig(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            if (trig) break;
            @(negedge clk);
        end
        if (k == 20) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_done_after(input int gap);
        repeat (gap) @(negedge clk);
        voice_done = 1'b1;
        @(negedge clk);
        voice_done = 1'b0;
    endtask

    initial begin
        vec_t        vecs[14];
        logic [31:0] rd;
        int          t0, w0, lat;
        logic        stall_ok;

        vecs[0]  = '{3'd0, 1'b0, 32'h0,         32'h0,  1'b1};
        vecs[1]  = '{3'd1, 1'b0, 32'h0,         32'h0,  1'b1};
        vecs[2]  = '{3'd2, 1'b0, 32'h0,         32'h0,  1'b1};
        vecs[3]  = '{3'd4, 1'b0, 32'h0,         32'h0,  1'b1};
        vecs[4]  = '{3'd5, 1'b0, 32'h0,         32'h0,  1'b1};
        vecs[5]  = '{3'd7, 1'b0, 32'h0,         32'h0,  1'b1};
        vecs[6]  = '{3'd1, 1'b1, 32'd5,         32'h0,  1'b0};
        vecs[7]  = '{3'd1, 1'b0, 32'h0,         32'd5,  1'b0};
        vecs[8]  = '{3'd1, 1'b1, 32'h1FF,       32'h0,  1'b0};
        vecs[9]  = '{3'd1, 1'b0, 32'h0,         32'h7F, 1'b0};
        vecs[10] = '{3'd0, 1'b1, 32'hFFFF_FFFE, 32'h0,  1'b0};
        vecs[11] = '{3'd0, 1'b0, 32'h0,         32'h2,  1'b0};
        vecs[12] = '{3'd1, 1'b1, 32'h0,         32'h0,  1'b1};
        vecs[13] = '{3'd1, 1'b0, 32'h0,         32'h0,  1'b1};

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_trig", {31'd0, trig}, 32'd0);
        check("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_dataout", dataout, 32'd0);
        check("rst_i2s_enable", {31'd0, i2s_enable}, 32'd1);
        reset_reg_N = 1'b1;
        @(negedge clk);

        // Register map table.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                write_reg(vecs[i].addr, vecs[i].data);
            end else begin
                read_reg(vecs[i].addr, rd);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
            check($sformatf("vec%0d_i2s", i), {31'd0, i2s_enable}, {31'd0, vecs[i].exp_i2s});
        end

        // dataout holds when read is low.
        read_reg(3'd0, rd);
        address = 3'd1;
        repeat (2) @(negedge clk);
        check("dataout_hold", dataout, 32'h2);

        // Full host period: PERIOD=4, voice_done 3 cycles after each trig.
        write_reg(3'd1, 32'd4);
        write_reg(3'd0, 32'd3);
        t0 = trig_total;
        w0 = wr_total;
        write_reg(3'd3, 32'd0);
        check("start_trig_next_cycle", {31'd0, trig}, 32'd1);
        for (int p = 0; p < 4; p++) begin
            wait_trig("p4_trig");
            pulse_done_after(3);
        end
        repeat (6) @(negedge clk);
        check("p4_trig_count", trig_total - t0, 32'd4);
        check("p4_wr_count", wr_total - w0, 32'd4);
        check("p4_irq", {31'd0, irq}, 32'd1);
        read_reg(3'd2, rd);
        check("p4_status", rd, 32'h0004_0002);
        write_reg(3'd2, 32'h2);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        read_reg(3'd2, rd);
        check("status_after_clear", rd, 32'h0004_0000);

        // FIFO full stall: PERIOD=2, level 64 held during PUSH.
        write_reg(3'd1, 32'd2);
        fifo_level = 7'd64;
        t0 = trig_total;
        w0 = wr_total;
        write_reg(3'd3, 32'd0);
        wait_trig("stall_trig");
        pulse_done_after(2);
        stall_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (fifo_wr) stall_ok = 1'b0;
            @(negedge clk);
        end
        check("stall_no_fifo_wr", {31'd0, stall_ok}, 32'd1);
        read_reg(3'd2, rd);
        check("stall_status", rd, 32'h0000_0001);
        write_reg(3'd1, 32'd9);
        write_reg(3'd3, 32'd0);
        check("stall_fifo_wr_still_0", {31'd0, fifo_wr}, 32'd0);
        fifo_level = 7'd63;
        @(negedge clk);
        check("unstall_fifo_wr", {31'd0, fifo_wr}, 32'd1);
        wait_trig("stall_trig2");
        pulse_done_after(3);
        repeat (6) @(negedge clk);
        check("stall_trig_count", trig_total - t0, 32'd2);
        check("stall_wr_count", wr_total - w0, 32'd2);
        read_reg(3'd1, rd);
        check("period_write_ignored", rd, 32'd2);
        read_reg(3'd2, rd);
        check("stall_status_done", rd, 32'h0002_0002);
        write_reg(3'd2, 32'h2);

        // Abort: clear run in WAIT_DONE after one push.
        write_reg(3'd1, 32'd3);
        write_reg(3'd3, 32'd0);
        wait_trig("abort_trig1");
        pulse_done_after(2);
        wait_trig("abort_trig2");
        @(negedge clk);
        write_reg(3'd0, 32'h2);
        read_reg(3'd2, rd);
        check("abort_status", rd, 32'h0);
        repeat (5) @(negedge clk);
        check("abort_no_irq", {31'd0, irq}, 32'd0);

        // I2S mode: lrck edges give trig within 3 cycles, voice_done gives fifo_wr.
        write_reg(3'd1, 32'd0);
        write_reg(3'd0, 32'd1);
        check("i2s_enable_on", {31'd0, i2s_enable}, 32'd1);
        t0 = trig_total;
        for (int e = 0; e < 3; e++) begin
            lrck = 1'b1;
            lat = 0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (trig) begin
                    lat = k;
                    break;
                end
            end
            check($sformatf("i2s_edge%0d_latency", e), (lat >= 1 && lat <= 3) ? 32'd1 : 32'd0,
                  32'd1);
            lrck = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("i2s_trig_count", trig_total - t0, 32'd3);
        voice_done = 1'b1;
        @(negedge clk);
        voice_done = 1'b0;
        check("i2s_fifo_wr", {31'd0, fifo_wr}, 32'd1);
        @(negedge clk);
        check("i2s_fifo_wr_one_cycle", {31'd0, fifo_wr}, 32'd0);
        read_reg(3'd2, rd);
        check("i2s_fsm_idle", {31'd0, rd[0]}, 32'd0);

`ifdef AUDIO_SCHED_OVR_CNT_EN
        // Overrun counter: two STARTs while busy.
        write_reg(3'd1, 32'd2);
        write_reg(3'd4, 32'd0);
        write_reg(3'd3, 32'd0);
        write_reg(3'd3, 32'd0);
        write_reg(3'd3, 32'd0);
        read_reg(3'd4, rd);
        check("ovr_count", rd, 32'd2);
        write_reg(3'd4, 32'd0);
        read_reg(3'd4, rd);
        check("ovr_cleared", rd, 32'd0);
        write_reg(3'd0, 32'd0);
`else
        read_reg(3'd4, rd);
        check("ovr_absent", rd, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
